// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high hex glyphs,
// segment bit positions and the polarity helper.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-high glyphs, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] apply_pol(input logic [6:0] seg_hi, input logic active_low);
    return active_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph.
// Zero latency; pure lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous input capture.
// Outputs are registered and reflect the scan position with one cycle of latency.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_tick_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SEG_OFF = apply_pol(7'h00, SEG_ACTIVE_LOW);
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                    slot_end;
  logic                    frame_end;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic                    cur_blank;

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    tick_d     = 1'b0;
    slot_end   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end  = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = frame_end ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Inputs are only taken at the frame boundary so a frame never mixes old and new values.
      if (frame_end) begin
        sh_dig_d   = digits_i;
        sh_dp_d    = dp_i;
        sh_blank_d = blank_i;
        tick_d     = 1'b1;
      end
    end
  end

  // Walk from the most significant digit; a digit is a leading zero while every digit above it is zero too.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_dig_q[4*i +: 4] == 4'h0);
      if (i > 0) begin
        lz_blank[i] = zero_run;
      end
    end
    eff_blank = sh_blank_q | ({NUM_DIGITS{LZ_BLANK}} & lz_blank);
  end

  assign cur_nib   = sh_dig_q[{idx_q, 2'b00} +: 4];
  assign cur_blank = eff_blank[idx_q];

  hex_to_seg7 u_hex (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    // Anodes stay off for the dead window at the start of each slot to stop ghosting.
    if (en && (cnt_q >= CNT_W'(DEAD_CYCLES))) begin
      an_d = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
      if (!cur_blank) begin
        seg_d = apply_pol(cur_seg, SEG_ACTIVE_LOW);
        dp_d  = sh_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_dig_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '1;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_dig_q   <= sh_dig_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign frame_tick_o = tick_q;

endmodule
